// File: rtl/xor_stream_scrambler.sv
// Additive stream scrambler: each data bit is XOR-ed with the feedback of a 7-bit
// x^7 + x^4 + 1 LFSR. Scrambling and descrambling are the same operation. One
// registered output stage with valid/ready flow control; the LFSR restarts from the
// seed register at every frame end.
module xor_stream_scrambler #(
  parameter int unsigned DATA_W   = 8,
  parameter logic [6:0]  SEED_RST = 7'h7F
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              seed_load,
  input  logic [6:0]        seed,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              in_frame
);

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  state_e            state_q, state_d;
  logic [6:0]        lfsr_q, lfsr_d;
  logic [6:0]        seed_q, seed_d;
  logic [6:0]        lfsr_beat;
  logic [6:0]        seed_nz;
  logic [DATA_W-1:0] scr_data;
  logic              fb;
  logic              xfer;
  logic              m_valid_q;
  logic [DATA_W-1:0] m_data_q;
  logic              m_last_q;

  // The stage can take a beat when empty or when its current beat leaves this cycle.
  assign s_ready  = !m_valid_q || m_ready;
  assign xfer     = s_valid && s_ready;
  // An all-zero seed would lock the LFSR at zero forever.
  assign seed_nz  = (seed == 7'd0) ? 7'h01 : seed;
  assign m_valid  = m_valid_q;
  assign m_data   = m_data_q;
  assign m_last   = m_last_q;
  assign in_frame = (state_q == StActive);

  // Unrolled LFSR: DATA_W steps per beat, LSB first, yielding scrambled data and post-beat state.
  always_comb begin
    lfsr_beat = lfsr_q;
    scr_data  = '0;
    fb        = 1'b0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      fb          = lfsr_beat[6] ^ lfsr_beat[3];
      scr_data[i] = s_data[i] ^ fb;
      lfsr_beat   = {lfsr_beat[5:0], fb};
    end
  end

  // Seed load beats frame-end reload, which beats normal beat advance.
  always_comb begin
    lfsr_d = lfsr_q;
    seed_d = seed_q;
    if (seed_load) begin
      seed_d = seed_nz;
      lfsr_d = seed_nz;
    end else if (xfer) begin
      lfsr_d = s_last ? seed_q : lfsr_beat;
    end
  end

  // Frame tracking: ACTIVE from a non-last beat until the last beat is accepted.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (xfer && !s_last) state_d = StActive;
      StActive: if (xfer && s_last)  state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // LFSR, seed register and frame state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q  <= SEED_RST;
      seed_q  <= SEED_RST;
      state_q <= StIdle;
    end else begin
      lfsr_q  <= lfsr_d;
      seed_q  <= seed_d;
      state_q <= state_d;
    end
  end

  // Output stage: load on transfer, empty when consumed, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
    end else if (xfer) begin
      m_valid_q <= 1'b1;
      m_data_q  <= scr_data;
      m_last_q  <= s_last;
    end else if (m_ready) begin
      m_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_xor_stream_scrambler.sv
// Bench: scrambler (a) chained into a descrambler (b). Expected beats are queued at
// input acceptance and popped by an independent monitor on each output handshake.
module tb_xor_stream_scrambler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       seed_load_a, seed_load_b;
  logic [6:0] seed;
  logic       s_valid, s_last;
  logic [7:0] s_data;
  logic       a_s_ready, a_m_valid, a_m_last, a_in_frame;
  logic [7:0] a_m_data;
  logic       b_s_ready, b_m_valid, b_m_ready, b_m_last, b_in_frame;
  logic [7:0] b_m_data;

  int n_cmp = 0;
  int n_bad = 0;

  logic [8:0] qa[$];
  logic [8:0] qb[$];
  logic       chk_b = 1'b1;

  // Reference model state: seed, bit offset into the frame keystream, frame flag.
  logic [6:0] mseed;
  int         mpos;
  logic       mframe;

  always #5 clk = ~clk;

  xor_stream_scrambler #(.DATA_W(8), .SEED_RST(7'h7F)) u_a (
    .clk(clk), .rst_n(rst_n), .seed_load(seed_load_a), .seed(seed),
    .s_valid(s_valid), .s_ready(a_s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(a_m_valid), .m_ready(b_s_ready), .m_data(a_m_data), .m_last(a_m_last),
    .in_frame(a_in_frame)
  );

  xor_stream_scrambler #(.DATA_W(8), .SEED_RST(7'h7F)) u_b (
    .clk(clk), .rst_n(rst_n), .seed_load(seed_load_b), .seed(seed),
    .s_valid(a_m_valid), .s_ready(b_s_ready), .s_data(a_m_data), .s_last(a_m_last),
    .m_valid(b_m_valid), .m_ready(b_m_ready), .m_data(b_m_data), .m_last(b_m_last),
    .in_frame(b_in_frame)
  );

  // Keystream as a bit sequence k[n] = k[n-7] ^ k[n-4], primed by the seed (oldest bit first).
  // The sequence has period 127, so the offset is reduced modulo 127.
  function automatic logic [7:0] keybyte(input logic [6:0] sd, input int pos);
    logic b [142];
    int   p = pos % 127;
    for (int k = 0; k < 7; k++) b[k] = sd[6-k];
    for (int n = 7; n < 7 + p + 8; n++) b[n] = b[n-7] ^ b[n-4];
    for (int i = 0; i < 8; i++) keybyte[i] = b[7+p+i];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  // One clock cycle of stimulus; records the expected response if the beat is accepted.
  task automatic drive(input logic v, input logic [7:0] d, input logic l, input logic sl_a,
                       input logic sl_b, input logic [6:0] sv, output logic xfer);
    @(negedge clk);
    s_valid = v; s_data = d; s_last = l;
    seed_load_a = sl_a; seed_load_b = sl_b; seed = sv;
    #1;
    xfer = v && a_s_ready;
    if (xfer) begin
      qa.push_back({l, d ^ keybyte(mseed, mpos)});
      if (chk_b) qb.push_back({l, d});
      mframe = !l;
    end
    if (sl_a) begin
      mseed = (sv == 7'd0) ? 7'h01 : sv;
      mpos  = 0;
    end else if (xfer) begin
      mpos = l ? 0 : mpos + 8;
    end
    @(posedge clk); #1;
    s_valid = 1'b0; seed_load_a = 1'b0; seed_load_b = 1'b0;
    check("in_frame", 64'(a_in_frame), 64'(mframe));
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    logic x = 1'b0;
    int   t = 0;
    while (!x && t < 50) begin
      drive(1'b1, d, l, 1'b0, 1'b0, 7'd0, x);
      t++;
    end
    if (!x) fail_now("send_timeout");
  endtask

  task automatic drain();
    int t = 0;
    b_m_ready = 1'b1;
    while ((qa.size() != 0 || qb.size() != 0) && t < 30) begin
      @(negedge clk);
      t++;
    end
    check("drain_a", 64'(qa.size()), 64'd0);
    check("drain_b", 64'(qb.size()), 64'd0);
  endtask

  task automatic model_reset();
    qa.delete(); qb.delete();
    mseed = 7'h7F; mpos = 0; mframe = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: pops and compares on every output handshake of either instance.
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clk); #2;
      if (rst_n) begin
        if (a_m_valid && b_s_ready) begin
          if (qa.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL a_extra: got %0h, expected no beat at %0t", a_m_data, $time);
          end else begin
            e = qa.pop_front();
            check("a_data", 64'(a_m_data), 64'(e[7:0]));
            check("a_last", 64'(a_m_last), 64'(e[8]));
          end
        end
        if (chk_b && b_m_valid && b_m_ready) begin
          if (qb.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL b_extra: got %0h, expected no beat at %0t", b_m_data, $time);
          end else begin
            e = qb.pop_front();
            check("b_data", 64'(b_m_data), 64'(e[7:0]));
            check("b_last", 64'(b_m_last), 64'(e[8]));
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] hold_a, hold_b, d;
    logic       x, l, v, pending;
    int         acc, cyc;

    rst_n = 1'b0; seed_load_a = 1'b0; seed_load_b = 1'b0; seed = 7'd0;
    s_valid = 1'b0; s_data = 8'd0; s_last = 1'b0; b_m_ready = 1'b1;
    model_reset();
    #3;
    check("rst_m_valid", 64'(a_m_valid), 64'd0);
    check("rst_m_data", 64'(a_m_data), 64'd0);
    check("rst_m_last", 64'(a_m_last), 64'd0);
    check("rst_in_frame", 64'(a_in_frame), 64'd0);
    check("rst_s_ready", 64'(a_s_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Two-beat frame of zeros, twice: both frames start from the default seed.
    repeat (2) begin
      send(8'h00, 1'b0);
      check("f_d0", 64'(a_m_data), 64'h70);
      check("f_l0", 64'(a_m_last), 64'd0);
      send(8'h00, 1'b1);
      check("f_d1", 64'(a_m_data), 64'h4F);
      check("f_l1", 64'(a_m_last), 64'd1);
    end
    drain();

    // Backpressure: b stalls, then a fills and must hold its beat.
    b_m_ready = 1'b0;
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    hold_a = a_m_data;
    hold_b = b_m_data;
    repeat (5) begin
      @(negedge clk); #1;
      check("bp_s_ready", 64'(a_s_ready), 64'd0);
      check("bp_m_valid", 64'(a_m_valid), 64'd1);
      check("bp_hold_a", 64'(a_m_data), 64'(hold_a));
      check("bp_hold_b", 64'(b_m_data), 64'(hold_b));
    end
    b_m_ready = 1'b1;
    send(8'h33, 1'b1);
    drain();

    // Random chained traffic with both instances seeded to 5A.
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 7'h5A, x);
    acc = 0; cyc = 0; pending = 1'b0; d = 8'h00; l = 1'b0;
    while (acc < 256 && cyc < 5000) begin
      if (!pending) begin
        d = 8'($urandom);
        l = ($urandom_range(0, 5) == 0);
      end
      v = pending || ($urandom_range(0, 3) != 0);
      b_m_ready = ($urandom_range(0, 2) != 0);
      drive(v, d, l, 1'b0, 1'b0, 7'd0, x);
      pending = v && !x;
      if (x) acc++;
      cyc++;
    end
    if (acc < 256) fail_now("random_beats");
    drain();

    // Reset mid-frame with a pending output; the loaded seed must be lost.
    send(8'hA5, 1'b0);
    check("mid_valid_pre", 64'(a_m_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_valid", 64'(a_m_valid), 64'd0);
    check("mid_in_frame", 64'(a_in_frame), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    send(8'h00, 1'b0);
    check("post_rst_d0", 64'(a_m_data), 64'h70);
    send(8'h00, 1'b1);
    drain();

    // Zero seed loaded in the same cycle as a beat; the descrambler is out of step here.
    chk_b = 1'b0;
    do_reset();
    drive(1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 7'h00, x);
    check("sl_xfer", 64'(x), 64'd1);
    check("sl_d0", 64'(a_m_data), 64'h70);
    send(8'h00, 1'b0);
    check("sl_d1", 64'(a_m_data), 64'hC8);
    // Seed load while the output beat is stalled must not disturb it.
    b_m_ready = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 7'h33, x);
    check("sl_hold_v", 64'(a_m_valid), 64'd1);
    check("sl_hold_d", 64'(a_m_data), 64'hC8);
    b_m_ready = 1'b1;
    send(8'h00, 1'b1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/xor_stream_scrambler.md
# xor_stream_scrambler

Additive (synchronous) stream scrambler that whitens a byte stream by XOR-ing each data bit with the output of a 7-bit LFSR with polynomial x^7 + x^4 + 1. It sits directly downstream of the bitwise XOR primitive and wraps it with sequence generation, valid/ready flow control and frame handling. Scrambling and descrambling are the same operation. A second instance loaded with the same seed restores the original data.

## Interface
- `DATA_W`, 8: data beat width in bits, processed LSB first; legal range 1–64.
- `SEED_RST`, 7'h7F: seed register and LFSR value after reset; must be non-zero.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset; assertion is immediate, release is synchronous to `clk`.
- `seed_load` in 1: single-cycle pulse; loads `seed` into the seed register and the LFSR.
- `seed` in 7: new seed; a value of 0 is replaced by 7'h01.
- `s_valid` in 1: input beat valid.
- `s_ready` out 1: block can accept an input beat.
- `s_data` in DATA_W: input beat.
- `s_last` in 1: marks the final beat of a frame.
- `m_valid` out 1: output beat valid.
- `m_ready` in 1: downstream accepts the output beat.
- `m_data` out DATA_W: scrambled beat.
- `m_last` out 1: copy of `s_last` for this beat.
- `in_frame` out 1: high between the first accepted beat of a frame and acceptance of its last beat.

## Operation
- LFSR state `s[6:0]`. For each bit i, with i = 0 first:
  - fb = s[6] ^ s[3]
  - out[i] = in[i] ^ fb
  - s = {s[5:0], fb}
- A beat advances the LFSR DATA_W steps in one cycle. The logic is a combinational unroll; no per-bit cycles are used.
- An input transfer occurs when `s_valid && s_ready`. On a transfer:
  - The scrambled data and `s_last` are registered into the single output stage.
  - The LFSR takes the post-beat state.
- `s_ready = !m_valid || m_ready`. This gives full throughput: one beat per cycle, with no combinational path from `s_valid` to `m_valid`.
- The output stage holds `m_data` and `m_last` stable while `m_valid && !m_ready`.
- Frame state machine has two states, IDLE and ACTIVE:
  - IDLE→ACTIVE on a transfer with `s_last`=0.
  - ACTIVE→IDLE on a transfer with `s_last`=1.
  - A transfer with `s_last`=1 in IDLE is a one-beat frame; the state stays IDLE.
  - `in_frame` is high exactly in ACTIVE.
- Frame end: after a transfer with `s_last`=1, the LFSR reloads from the seed register. Every frame therefore starts from the seed.
- `seed_load` has priority over everything that updates the LFSR and seed register:
  - A beat transferred in the same cycle is scrambled with the old LFSR state.
  - The next LFSR state is the new seed, not the post-beat or frame-end value.
  - FSM state is unaffected.
- The LFSR can never reach all-zero: the seed is forced non-zero and the feedback polynomial is primitive.

## Timing
- Reset values:
  - `m_valid`=0, `m_data`=0, `m_last`=0, `in_frame`=0.
  - `s_ready`=1.
  - LFSR and seed register = SEED_RST.
  - FSM = IDLE.
- Latency: 1 cycle from input transfer to `m_valid` high.
- Back-to-back transfers with `m_ready` held high give one output beat per cycle with no bubbles.
- Reset asserted mid-frame:
  - Pending output is discarded.
  - FSM returns to IDLE.
  - The seed register reverts to SEED_RST, losing any loaded seed.
- `seed_load` while `m_valid && !m_ready` does not alter the held output beat.

## Test plan
- Reset, DATA_W=8, default seed. Send 0x00 (`s_last`=0), then 0x00 (`s_last`=1), with `m_ready`=1.
  - Expect `m_data`=0x70 then 0x4F.
  - Expect `m_last`=0 then 1.
  - Expect `in_frame` high for exactly 1 cycle.
- Send the same frame again.
  - Expect 0x70, 0x4F again, confirming the seed reload at frame end.
- Chain two instances, both seeded with 7'h5A, and send 256 random beats with random `s_valid` and `m_ready`.
  - The second instance's output equals the input sequence exactly, with `m_last` aligned.
- Backpressure: hold `m_ready`=0 for 5 cycles after the first beat.
  - `s_ready`=0 while the stage is full.
  - `m_data` stays stable.
  - No beat is lost or duplicated.
- `seed_load` with `seed`=0 in the same cycle as a transfer of 0x00 from reset state:
  - That beat outputs 0x70.
  - The next beat is scrambled from state 7'h01.
- Assert `rst_n` low mid-frame while `m_valid`=1.
  - `m_valid` drops immediately and `in_frame`=0.
  - The next frame outputs 0x70 for an input of 0x00.
